// File: rtl/lpm_pipe_pkg.sv
// Shared definitions for the LPM indication pipe packer/unpacker pair.
package lpm_pipe_pkg;

    localparam int unsigned PIPE_WIDTH     = 32;
    localparam int unsigned LPM_IND_OUT_ID = 5;
    localparam int unsigned ID_LSB         = 16;
    localparam int unsigned ID_WIDTH       = 16;
    localparam int unsigned LEN_WIDTH      = 16;

    // Header beat layout: method id in the upper half, payload length in beats below.
    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [LEN_WIDTH-1:0] len;
    } pipe_hdr_t;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DELIVER,
        ST_DRAIN
    } p2m_state_t;

endpackage

// File: rtl/p2m_beat_assembler.sv
// Collects 32-bit payload beats into a DATA_WIDTH register, first beat at the LSBs.
module p2m_beat_assembler
    import lpm_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [PIPE_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  done
);

    localparam int unsigned NBEATS = DATA_WIDTH / PIPE_WIDTH;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Slot write for the current beat and beat counter advance; done flags the final beat.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        done   = load && (cnt_q == LAST_BEAT);
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
            for (int unsigned i = 0; i < NBEATS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    data_d[i*PIPE_WIDTH +: PIPE_WIDTH] = din;
                end
            end
        end
    end

    // Counter and data register; data holds between messages so the output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/p2m_lpm_indication.sv
// Pipe-to-method receiver for LpmIndication: reassembles header+payload into one out() call,
// draining and counting messages with an unknown id or a wrong length.
module p2m_lpm_indication
    import lpm_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned METHOD_ID  = LPM_IND_OUT_ID,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  pipe_enq__ENA,
    input  logic [31:0]           pipe_enq_v,
    output logic                  pipe_enq__RDY,
    output logic                  out__ENA,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out__RDY,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int unsigned NBEATS = DATA_WIDTH / PIPE_WIDTH;
    localparam logic [LEN_WIDTH-1:0] NBEATS_LEN = LEN_WIDTH'(NBEATS);
    localparam logic [ID_WIDTH-1:0]  OUT_ID     = ID_WIDTH'(METHOD_ID);

    p2m_state_t           state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    pipe_hdr_t            hdr;
    logic                 beat;
    logic                 asm_load;
    logic                 asm_clear;
    logic                 asm_done;

    assign hdr.id  = pipe_enq_v[ID_LSB +: ID_WIDTH];
    assign hdr.len = pipe_enq_v[LEN_WIDTH-1:0];
    assign beat    = pipe_enq__ENA && pipe_enq__RDY;

    p2m_beat_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk  (CLK),
        .rst_n(nRST),
        .clear(asm_clear),
        .load (asm_load),
        .din  (pipe_enq_v),
        .data (out_data),
        .done (asm_done)
    );

    // State, drain count and saturating error counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_HDR;
            rem_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Next-state: header decode, payload collection, delivery handshake and drain.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        err_d     = err_q;
        asm_load  = 1'b0;
        asm_clear = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (beat) begin
                    if (hdr.id == OUT_ID && hdr.len == NBEATS_LEN) begin
                        state_d   = ST_PAYLOAD;
                        asm_clear = 1'b1;
                    end else begin
                        err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                        if (hdr.len != '0) begin
                            state_d = ST_DRAIN;
                            rem_d   = hdr.len;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                asm_load = beat;
                if (asm_done) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (out__RDY) begin
                    state_d = ST_HDR;
                end
            end
            ST_DRAIN: begin
                if (beat) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        pipe_enq__RDY = (state_q != ST_DELIVER);
        out__ENA      = (state_q == ST_DELIVER);
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_p2m_lpm_indication.sv
// Directed self-checking bench for p2m_lpm_indication (DATA_WIDTH=64, METHOD_ID=5, ERR_WIDTH=8).
module tb_p2m_lpm_indication;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b1;
    logic        ena  = 1'b0;
    logic [31:0] vdat = '0;
    logic        rdy;
    logic        oena;
    logic [63:0] odata;
    logic        ordy = 1'b1;
    logic [7:0]  err;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    bit          collect  = 1'b0;
    logic [63:0] dlv_data[$];
    int unsigned dlv_cyc[$];

    p2m_lpm_indication #(
        .DATA_WIDTH(64),
        .METHOD_ID (5),
        .ERR_WIDTH (8)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pipe_enq__ENA(ena),
        .pipe_enq_v   (vdat),
        .pipe_enq__RDY(rdy),
        .out__ENA     (oena),
        .out_data     (odata),
        .out__RDY     (ordy),
        .err_count    (err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (collect && oena && ordy) begin
            dlv_data.push_back(odata);
            dlv_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a beat and hold it until the receiver takes it.
    task automatic send_beat(input logic [31:0] v);
        int unsigned n = 0;
        ena  = 1'b1;
        vdat = v;
        while (!rdy && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) check("beat_timeout", 64'(n), 64'd0);
        @(posedge CLK); #1;
        ena = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] h, input logic [31:0] b0, input logic [31:0] b1);
        send_beat(h);
        send_beat(b0);
        send_beat(b1);
    endtask

    // Called right after the last payload beat with out__RDY already high.
    task automatic expect_delivery(input string tag, input logic [63:0] exp);
        check({tag, "_ena"}, 64'(oena), 64'd1);
        check({tag, "_data"}, odata, exp);
        check({tag, "_rdy_low"}, 64'(rdy), 64'd0);
        @(posedge CLK); #1;
        check({tag, "_ena_drop"}, 64'(oena), 64'd0);
        check({tag, "_rdy_back"}, 64'(rdy), 64'd1);
    endtask

    task automatic do_reset();
        ena  = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_ena", 64'(oena), 64'd0);
        check("rst_data", odata, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        check("rst_rdy", 64'(rdy), 64'd1);
    endtask

    initial begin
        logic [63:0] exp_b2b[3];

        #2;
        do_reset();

        // 1: basic delivery
        ordy = 1'b1;
        send_msg(32'h0005_0002, 32'h1111_2222, 32'h3333_4444);
        expect_delivery("t1", 64'h3333_4444_1111_2222);
        check("t1_err", 64'(err), 64'd0);

        // 2: consumer stalls for 5 cycles
        ordy = 1'b0;
        send_msg(32'h0005_0002, 32'h1111_2222, 32'h3333_4444);
        for (int i = 0; i < 6; i++) begin
            check("t2_ena_hold", 64'(oena), 64'd1);
            check("t2_data_hold", odata, 64'h3333_4444_1111_2222);
            check("t2_rdy_low", 64'(rdy), 64'd0);
            if (i == 5) ordy = 1'b1;
            @(posedge CLK); #1;
        end
        check("t2_ena_drop", 64'(oena), 64'd0);
        check("t2_rdy_back", 64'(rdy), 64'd1);

        // 3: unknown id drained, then a good message
        send_beat(32'h0007_0003);
        for (int i = 0; i < 3; i++) begin
            check("t3_drain_rdy", 64'(rdy), 64'd1);
            send_beat(32'hCAFE_0000 + 32'(i));
            check("t3_drain_no_ena", 64'(oena), 64'd0);
        end
        check("t3_err", 64'(err), 64'd1);
        send_msg(32'h0005_0002, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
        expect_delivery("t3", 64'hCCCC_DDDD_AAAA_BBBB);

        // 4: wrong length drained, zero-length mismatch counted without drain
        do_reset();
        send_beat(32'h0005_0003);
        for (int i = 0; i < 3; i++) begin
            send_beat(32'h0005_0002);
            check("t4_drain_no_ena", 64'(oena), 64'd0);
        end
        check("t4_err1", 64'(err), 64'd1);
        send_beat(32'h0009_0000);
        check("t4_err2", 64'(err), 64'd2);
        send_msg(32'h0005_0002, 32'h0BAD_F00D, 32'h1234_5678);
        expect_delivery("t4", 64'h1234_5678_0BAD_F00D);

        // 5: reset mid-message
        send_beat(32'h0005_0002);
        send_beat(32'hDEAD_BEEF);
        nRST = 1'b0;
        #1;
        check("t5_rst_ena", 64'(oena), 64'd0);
        check("t5_rst_data", odata, 64'd0);
        check("t5_rst_err", 64'(err), 64'd0);
        check("t5_rst_rdy", 64'(rdy), 64'd1);
        @(posedge CLK); #1;
        nRST = 1'b1;
        send_msg(32'h0005_0002, 32'h0123_4567, 32'h89AB_CDEF);
        expect_delivery("t5", 64'h89AB_CDEF_0123_4567);

        // 6a: error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_beat(32'h0001_0000);
            if (i == 253) check("t6_err_fe", 64'(err), 64'hFE);
            if (i == 254) check("t6_err_ff", 64'(err), 64'hFF);
        end
        check("t6_err_sat", 64'(err), 64'hFF);
        check("t6_no_ena", 64'(oena), 64'd0);

        // 6b: back-to-back messages, valid held high
        exp_b2b[0] = 64'h2000_0001_1000_0001;
        exp_b2b[1] = 64'h2000_0002_1000_0002;
        exp_b2b[2] = 64'h2000_0003_1000_0003;
        ordy    = 1'b1;
        collect = 1'b1;
        for (int m = 0; m < 3; m++) begin
            send_msg(32'h0005_0002, 32'h1000_0001 + 32'(m), 32'h2000_0001 + 32'(m));
        end
        repeat (2) @(posedge CLK);
        #1;
        collect = 1'b0;
        check("t6_dlv_count", 64'(dlv_data.size()), 64'd3);
        for (int i = 0; i < dlv_data.size() && i < 3; i++) begin
            check("t6_dlv_data", dlv_data[i], exp_b2b[i]);
            if (i > 0) check("t6_period", 64'(dlv_cyc[i] - dlv_cyc[i-1]), 64'd4);
        end
        check("t6_err_final", 64'(err), 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p2m_lpm_indication.md
Name: p2m_lpm_indication

Overview:
Pipe-to-method receiver for the LpmIndication interface, the inverse of the method-to-pipe packer. It accepts a stream of 32-bit pipe beats, reassembles one indication message (header plus payload) and issues a single `out(data)` method call to the local indication consumer. Messages with an unknown method id or a wrong length are drained and counted, never delivered. It sits between the host/portal channel demux and the LPM indication sink.

Parameters:
DATA_WIDTH, 64, width of `out$data`; must be a multiple of 32.
METHOD_ID, 5, header method id that selects `out`.
ERR_WIDTH, 8, width of the saturating error counter.

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
pipe_enq__ENA  input  1  beat valid from pipe
pipe_enq$v  input  32  beat data
pipe_enq__RDY  output  1  receiver can accept a beat this cycle
out__ENA  output  1  method call valid to indication consumer
out$data  output  DATA_WIDTH  method argument
out__RDY  input  1  consumer accepts the call
err_count  output  ERR_WIDTH  number of dropped messages, saturating

Behaviour:
- Interface: one clock `CLK`; reset `nRST` is asynchronous, active-low.
- Beat transfer occurs when `pipe_enq__ENA && pipe_enq__RDY`.
- Method call completes when `out__ENA && out__RDY`.
- Message format:
  - Header beat: [31:16] = method id; [15:0] = payload length in beats (L).
  - Payload beats follow in order. Payload beat k goes to `out$data[32k+31:32k]`, first beat at the LSBs.
- NBEATS = DATA_WIDTH/32.
- States: HDR, PAYLOAD, DELIVER, DRAIN.
  - HDR: `pipe_enq__RDY` = 1. On a header beat:
    - id == METHOD_ID and L == NBEATS: go to PAYLOAD, beat counter = 0.
    - Else, if L != 0: go to DRAIN, remaining = L, `err_count` += 1.
    - Else (L == 0, mismatch): stay in HDR, `err_count` += 1.
  - PAYLOAD: `pipe_enq__RDY` = 1. Each beat is written into its data slot and the counter increments. The last beat (counter == NBEATS-1) moves to DELIVER.
  - DELIVER: `pipe_enq__RDY` = 0, `out__ENA` = 1.
    - `out$data` is registered and holds stable until `out__RDY`.
    - On acceptance, go to HDR.
  - DRAIN: `pipe_enq__RDY` = 1. Each beat is discarded and decrements remaining. The beat that takes remaining to 0 returns to HDR.
- `pipe_enq__RDY` and `out__ENA` are decoded from registered state only. There is no combinational path from `out__RDY` to `pipe_enq__RDY`.
- Latency:
  - `out__ENA` rises the cycle after the last payload beat is accepted.
  - Minimum message period is NBEATS+2 cycles.
- `err_count` saturates at all-ones and never wraps.
- Reset values (at any time):
  - state = HDR.
  - `out__ENA` = 0, `out$data` = 0, `err_count` = 0.
  - `pipe_enq__RDY` = 1 from the first cycle after reset deassertion.
  - Reset mid-message discards any partial payload; the next beat is treated as a header.
- `pipe_enq__ENA` while `pipe_enq__RDY` = 0 has no effect; the sender must hold the beat.
- L is compared at the full 16 bits. L > NBEATS with a correct id is an error and is drained, never truncated.

Decomposition:
- Shared package `lpm_pipe_pkg` holds:
  - `LPM_IND_OUT_ID` (=5).
  - Header field offsets/widths (ID_LSB=16, LEN_WIDTH=16).
  - A `pipe_hdr_t` packed struct {id[15:0], len[15:0]}.
  - A state enum `p2m_state_t`.
- The M2P packer shares the package.
- One natural sub-module: `p2m_beat_assembler`. It holds the beat counter and the shift/slot write into the DATA_WIDTH register, with `load`, `clear` and `done` signals. The FSM and error counter stay in the top module.

Test Plan:
1. Reset, then header 0x0005_0002, beats 0x1111_2222, 0x3333_4444, `out__RDY`=1 -> `out__ENA` high exactly one cycle, `out$data`=0x3333_4444_1111_2222, `err_count`=0.
2. Same message with `out__RDY` held 0 for 5 cycles -> `out__ENA` and data stable for 6 cycles, `pipe_enq__RDY`=0 throughout, then the next header is accepted the cycle after the call completes.
3. Header 0x0007_0003 plus 3 beats, then a valid id-5 message -> first message drained with no `out__ENA`, `err_count`=1, second delivered correctly.
4. Header 0x0005_0003 (wrong length) plus 3 beats -> drained, `err_count`=1. Header 0x0009_0000 -> `err_count`=2 with no drain cycles.
5. Assert `nRST` after the header and one payload beat, release, send a full valid message -> only the new message is delivered, its data uncorrupted.
6. 260 bad headers with L=0 -> `err_count` saturates at 0xFF. Back-to-back valid messages with `pipe_enq__ENA` held high -> one delivery per 4 cycles.
